wb_cmd_master: RTL

//  Wishbone initiator driven by a byte-stream command channel (host link: UART/SPI/USB front end).

---
 rtl/wb_cmd_master_pkg.sv | 22 ++
 rtl/wb_cmd_master.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master_pkg.sv
// rtl/wb_cmd_master_pkg.sv - opcodes, status codes and FSM states for wb_cmd_master
// Purpose: shared constants for the byte-command Wishbone initiator.
// Ports: none (package).
package wb_cmd_master_pkg;

  localparam logic [7:0] OP_WR      = 8'h01;
  localparam logic [7:0] OP_RD      = 8'h02;

  localparam logic [7:0] ST_OK      = 8'hA5;
  localparam logic [7:0] ST_TIMEOUT = 8'hE1;
  localparam logic [7:0] ST_BADOP   = 8'hE2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_BUS   = 3'd3,
    S_STAT  = 3'd4,
    S_RDAT  = 3'd5
  } state_t;

endpackage

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - byte-stream command channel to single-beat Wishbone initiator
// Purpose: parses OP/ADDR[/WDATA] packets, runs one classic Wishbone cycle, returns
//   STATUS[/RDATA] bytes.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_rx_data/valid, o_rx_ready   command byte stream in
//   o_tx_data/valid, i_tx_ready   response byte stream out
//   o_wb_addr/dat/we/cyc          Wishbone initiator outputs
//   i_wb_dat, i_wb_ack            Wishbone slave response
//   o_busy                        high whenever not idle
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter logic [15:0] BUS_TIMEOUT  = 16'd1000,
  parameter logic [15:0] RX_GAP_LIMIT = 16'd50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  output logic        o_busy
);

  state_t      state, state_nxt;
  logic [1:0]  bcnt;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic        is_rd;
  logic [31:0] addr_r, wdat_r, rdat_r;
  logic [7:0]  status_r;
  logic        rx_fire, tx_fire, gap_hit, to_hit;

  assign rx_fire = i_rx_valid & o_rx_ready;
  assign tx_fire = o_tx_valid & i_tx_ready;
  assign cnt_inc = cnt + 16'd1;

  // cnt is shared: idle cycles between bytes while parsing, cycles of cyc high in BUS.
  // Hits fire on the edge where the count would reach the limit, so cyc stays high
  // exactly BUS_TIMEOUT cycles. An ack in the same cycle beats the timeout.
  assign gap_hit = (RX_GAP_LIMIT != 16'd0) && !rx_fire && (cnt_inc == RX_GAP_LIMIT);
  assign to_hit  = (BUS_TIMEOUT != 16'd0) && !i_wb_ack && (cnt_inc == BUS_TIMEOUT);

  assign o_wb_addr = addr_r;
  assign o_wb_dat  = wdat_r;
  assign o_wb_we   = (state == S_BUS) && !is_rd;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    o_rx_ready = 1'b0;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    o_wb_cyc   = 1'b0;
    o_busy     = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        o_rx_ready = 1'b1;
        if (rx_fire) begin
          if (i_rx_data == OP_WR || i_rx_data == OP_RD) state_nxt = S_ADDR;
          else                                           state_nxt = S_STAT;
        end
      end
      S_ADDR: begin
        o_rx_ready = 1'b1;
        if (rx_fire && bcnt == 2'd3) state_nxt = is_rd ? S_BUS : S_WDATA;
        else if (gap_hit)            state_nxt = S_IDLE;
      end
      S_WDATA: begin
        o_rx_ready = 1'b1;
        if (rx_fire && bcnt == 2'd3) state_nxt = S_BUS;
        else if (gap_hit)            state_nxt = S_IDLE;
      end
      S_BUS: begin
        o_wb_cyc = 1'b1;
        if (i_wb_ack || to_hit) state_nxt = S_STAT;
      end
      S_STAT: begin
        o_tx_valid = 1'b1;
        o_tx_data  = status_r;
        if (tx_fire) state_nxt = (is_rd && status_r == ST_OK) ? S_RDAT : S_IDLE;
      end
      S_RDAT: begin
        o_tx_valid = 1'b1;
        o_tx_data  = rdat_r[31:24];
        if (tx_fire && bcnt == 2'd3) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bcnt     <= 2'd0;
      cnt      <= 16'd0;
      is_rd    <= 1'b0;
      addr_r   <= 32'd0;
      wdat_r   <= 32'd0;
      rdat_r   <= 32'd0;
      status_r <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          bcnt <= 2'd0;
          cnt  <= 16'd0;
          if (rx_fire) begin
            is_rd    <= (i_rx_data == OP_RD);
            // Overwritten in BUS for valid opcodes; survives only for a bad op.
            status_r <= ST_BADOP;
          end
        end
        S_ADDR, S_WDATA: begin
          if (rx_fire) begin
            if (state == S_ADDR) addr_r <= {addr_r[23:0], i_rx_data};
            else                 wdat_r <= {wdat_r[23:0], i_rx_data};
            bcnt <= bcnt + 2'd1;
            cnt  <= 16'd0;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt_inc;
          end
        end
        S_BUS: begin
          if (cnt != 16'hFFFF) cnt <= cnt_inc;
          if (i_wb_ack) begin
            status_r <= ST_OK;
            if (is_rd) rdat_r <= i_wb_dat;
          end else if (to_hit) begin
            status_r <= ST_TIMEOUT;
          end
        end
        S_STAT: begin
          bcnt <= 2'd0;
          cnt  <= 16'd0;
        end
        S_RDAT: begin
          if (tx_fire) begin
            rdat_r <= {rdat_r[23:0], 8'h00};
            bcnt   <= bcnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
